// File: rtl/add_pipe_pkg.sv
// Shared types and parameters for the pipelined multi-operand modular adder.
// The guard-bit width is derived here so that the top and the bench agree on it.
package add_pipe_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_OPS = 5;

    // Guard bits needed so that the sum of n WIDTH-bit operands never wraps.
    function automatic int calc_ext(input int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic use_acc;
        logic acc_wr;
    } stage_tag_t;

endpackage

// File: rtl/add_pipe_multi_csa.sv
// 3:2 carry-save compressor; the carry vector is returned already weighted (shifted by one).
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_carry = w_maj << 1;

endmodule

// File: rtl/add_pipe_multi.sv
// Two-stage multi-operand modular adder: a carry-save tree feeds an output
// register that resolves the sum and optionally folds in a running accumulator.
module add_pipe_multi
    import add_pipe_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [NUM_OPS*WIDTH-1:0] DataIn,
    input  logic                     UseAcc,
    input  logic                     AccWr,
    input  logic                     AccClr,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         DataOut,
    output logic                     Overflow,
    output logic [WIDTH-1:0]         AccOut
);

    localparam int EXT = calc_ext(NUM_OPS);
    localparam int EW  = WIDTH + EXT;

    logic [EW-1:0] w_tree_sum;
    logic [EW-1:0] w_tree_car;
    logic [EW-1:0] r_s1_sum;
    logic [EW-1:0] r_s1_car;
    stage_tag_t    r_s1_tag;
    logic          r_s1_valid;
    logic          r_out_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;
    logic          w_s1_load;
    logic          w_s2_load;
    logic [EW:0]   w_exact;
    logic [WIDTH-1:0] w_acc_term;

    // Linear chain of compressors: each level folds one more operand into (sum, carry).
    // Since the exact total fits in EW bits, dropping the carry MSB never loses value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS - 2; gi++) begin : g_lvl
            logic [EW-1:0] w_a;
            logic [EW-1:0] w_b;
            logic [EW-1:0] w_s;
            logic [EW-1:0] w_c;
            if (gi == 0) begin : g_first
                assign w_a = {{EXT{1'b0}}, DataIn[0 +: WIDTH]};
                assign w_b = {{EXT{1'b0}}, DataIn[WIDTH +: WIDTH]};
            end else begin : g_next
                assign w_a = g_lvl[gi-1].w_s;
                assign w_b = g_lvl[gi-1].w_c;
            end
            csa_3to2 #(.W(EW)) u_csa (
                .i_a     (w_a),
                .i_b     (w_b),
                .i_c     ({{EXT{1'b0}}, DataIn[(gi+2)*WIDTH +: WIDTH]}),
                .o_sum   (w_s),
                .o_carry (w_c)
            );
        end
        if (NUM_OPS == 2) begin : g_two
            assign w_tree_sum = {{EXT{1'b0}}, DataIn[0 +: WIDTH]};
            assign w_tree_car = {{EXT{1'b0}}, DataIn[WIDTH +: WIDTH]};
        end else begin : g_tree
            assign w_tree_sum = g_lvl[NUM_OPS-3].w_s;
            assign w_tree_car = g_lvl[NUM_OPS-3].w_c;
        end
    endgenerate

    assign w_s2_load = r_s1_valid && (!r_out_valid || OutReady);
    assign InReady   = !r_s1_valid || w_s2_load;
    assign w_s1_load = InValid && InReady;

    // Accumulator is sampled at the S2-load edge, so chained items see the previous result.
    assign w_acc_term = r_s1_tag.use_acc ? r_acc : '0;
    assign w_exact    = {1'b0, r_s1_sum} + {1'b0, r_s1_car} + {{(EXT+1){1'b0}}, w_acc_term};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_car   <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_sum   <= w_tree_sum;
                r_s1_car   <= w_tree_car;
                r_s1_tag   <= '{use_acc: UseAcc, acc_wr: AccWr};
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_data      <= w_exact[WIDTH-1:0];
                r_ovf       <= |w_exact[EW:WIDTH];
            end else if (OutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc <= '0;
        end else if (AccClr) begin
            r_acc <= '0;
        end else if (w_s2_load && r_s1_tag.acc_wr) begin
            r_acc <= w_exact[WIDTH-1:0];
        end
    end

    assign OutValid = r_out_valid;
    assign DataOut  = r_data;
    assign Overflow = r_ovf;
    assign AccOut   = r_acc;

endmodule

// File: tb/tb_add_pipe_multi.sv
// Directed bench for add_pipe_multi (WIDTH=32, NUM_OPS=5): vector table plus
// hand-written sequences for chaining, backpressure, accumulator clear and reset.
module tb_add_pipe_multi;

    localparam int W = 32;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] data_in;
    logic           use_acc;
    logic           acc_wr;
    logic           acc_clr;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   data_out;
    logic           overflow;
    logic [W-1:0]   acc_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N*W-1:0] ops;
        logic [W-1:0]   exp_data;
        logic           exp_ovf;
    } vec_t;

    vec_t vecs [8];

    add_pipe_multi #(.WIDTH(W), .NUM_OPS(N)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .DataIn   (data_in),
        .UseAcc   (use_acc),
        .AccWr    (acc_wr),
        .AccClr   (acc_clr),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .DataOut  (data_out),
        .Overflow (overflow),
        .AccOut   (acc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // One isolated bundle: checks two-edge latency, result and overflow.
    task automatic run_vec(input logic [N*W-1:0] ops, input logic ua, input logic aw,
                           input logic [W-1:0] ed, input logic eo, input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = ops;
        use_acc   = ua;
        acc_wr    = aw;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        use_acc  = 1'b0;
        acc_wr   = 1'b0;
        check({nm, " early_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({nm, " valid"}, 64'(out_valid), 64'd1);
        check({nm, " data"}, 64'(data_out), 64'(ed));
        check({nm, " ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        int sent;
        int got;
        logic [W-1:0] exp_q [4];

        vecs[0] = '{{32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 32'd15, 1'b0};
        vecs[1] = '{{5{32'hFFFF_FFFF}}, 32'hFFFF_FFFB, 1'b1};
        vecs[2] = '{{32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, 32'd0, 1'b1};
        vecs[3] = '{{32'd0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, 32'd0, 1'b1};
        vecs[4] = '{{32'h0101_0101, 32'd0, 32'd0, 32'h1111_1111, 32'h1234_5678}, 32'h2446_688A, 1'b0};
        vecs[5] = '{{5{32'd0}}, 32'd0, 1'b0};
        vecs[6] = '{{32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{{32'd1, 32'd0, 32'd0, 32'h1000_0000, 32'hDEAD_BEEF}, 32'hEEAD_BEF0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; use_acc = 1'b0;
        acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset data_out", 64'(data_out), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset acc_out", 64'(acc_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].ops, 1'b0, 1'b0, vecs[i].exp_data, vecs[i].exp_ovf,
                    $sformatf("vec%0d", i));
        end

        // Accumulator chaining: three back-to-back {10,0,0,0,0} with UseAcc/AccWr.
        got = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (cyc < 3);
            data_in   = (cyc < 3) ? {128'd0, 32'd10} : '0;
            use_acc   = (cyc < 3);
            acc_wr    = (cyc < 3);
            #1;
            if (out_valid) begin
                check($sformatf("chain data%0d", got), 64'(data_out), 64'(10 * (got + 1)));
                check($sformatf("chain slot%0d", got), 64'(cyc), 64'(got + 2));
                got++;
            end
        end
        check("chain count", 64'(got), 64'd3);
        check("chain acc_out", 64'(acc_out), 64'd30);
        in_valid = 1'b0; use_acc = 1'b0; acc_wr = 1'b0;

        run_vec({128'd0, 32'd5}, 1'b1, 1'b0, 32'd35, 1'b0, "useacc_nowr");
        check("useacc_nowr acc_out", 64'(acc_out), 64'd30);
        run_vec({5{32'hFFFF_FFFF}}, 1'b1, 1'b0, 32'd25, 1'b1, "acc_overflow");

        // Backpressure: four bundles k*{1,1,1,1,1} with OutReady low for 5 cycles.
        for (int k = 0; k < 4; k++) exp_q[k] = 32'(5 * (k + 1));
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            data_in   = (sent < 4) ? {5{32'(sent + 1)}} : '0;
            #1;
            if (cyc < 2) check($sformatf("bp in_ready c%0d", cyc), 64'(in_ready), 64'd1);
            if (cyc >= 2 && cyc < 5) begin
                check($sformatf("bp stall in_ready c%0d", cyc), 64'(in_ready), 64'd0);
                check($sformatf("bp stall hold c%0d", cyc), 64'(data_out), 64'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp out%0d", got), 64'(data_out), 64'(exp_q[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp out count", 64'(got), 64'd4);
        in_valid = 1'b0;

        // AccClr on the same edge that an AccWr item with value 7 loads S2.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = {128'd0, 32'd7};
        acc_wr    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; acc_wr = 1'b0; data_in = '0;
        acc_clr  = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr collide data", 64'(data_out), 64'd7);
        check("clr collide valid", 64'(out_valid), 64'd1);
        check("clr collide acc_out", 64'(acc_out), 64'd0);

        // Reset with two items in flight and Acc=0x55.
        run_vec({128'd0, 32'h55}, 1'b0, 1'b1, 32'h55, 1'b0, "acc55");
        @(negedge clk);
        check("acc55 acc_out", 64'(acc_out), 64'h55);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = {5{32'd3}};
        @(negedge clk);
        data_in = {5{32'd4}};
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        check("inflight out_valid", 64'(out_valid), 64'd1);
        check("inflight in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset acc_out", 64'(acc_out), 64'd0);
        check("midreset data_out", 64'(data_out), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_vec({5{32'd1}}, 1'b0, 1'b0, 32'd5, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
